// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
// Shares one cache/main-memory datapath between two requesters (e.g.
// instruction and data fetch). One request is granted at a time using
// round-robin priority. The datapath address is held for the hit-lookup
// window and, on a miss, for the refill window. The result is returned to
// the winning port together with a one-cycle acknowledge.
//
// Ports:
//   clk              single clock, rising edge
//   rst              asynchronous active-low reset
//   req0/req1        level requests, held until the matching ack
//   addr0/addr1      request addresses, stable while req is high
//   ack0/ack1        one-cycle response strobes
//   rdata0/rdata1    response data, valid while ackN is high
//   hit0/hit1        1 = served as hit, valid while ackN is high
//   dp_addr          address driven into the datapath
//   dp_hit/dp_data   datapath hit flag and read data
//   busy             high in any state other than IDLE
//
// Optional feature (macro CACHE_PORT_ARBITER_STATS_EN):
//   stats_clr        synchronous clear for the statistics counters
//   hit_cnt/miss_cnt saturating 16-bit hit and miss counters
module cache_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int HIT_LAT  = 1,
    parameter int MISS_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              hit0,
    output logic              hit1,
    output logic [ADDR_W-1:0] dp_addr,
    input  logic              dp_hit,
    input  logic [DATA_W-1:0] dp_data,
`ifdef CACHE_PORT_ARBITER_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
`endif
    output logic              busy
);

    localparam int MAX_LAT = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             gnt, gnt_nx;    // port owning the current access
    logic             prio;           // port favoured when both request
    logic             do_grant;
    logic             capture;
    logic             cap_hit;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        do_grant = 1'b0;
        capture  = 1'b0;
        cap_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    do_grant = 1'b1;
                    gnt_nx   = (req0 && req1) ? prio : req1;
                    cnt_nx   = CNT_W'(HIT_LAT - 1);
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cnt == '0) begin
                    if (dp_hit) begin
                        capture  = 1'b1;
                        cap_hit  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        cnt_nx   = CNT_W'(MISS_LAT - 1);
                        state_nx = MISS;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            MISS: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ack is registered on the capture edge, so it is high exactly while
    // the FSM sits in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= 1'b0;
            prio    <= 1'b0;
            dp_addr <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            hit0    <= 1'b0;
            hit1    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gnt   <= gnt_nx;
            ack0  <= capture && !gnt;
            ack1  <= capture && gnt;
            if (do_grant) begin
                dp_addr <= gnt_nx ? addr1 : addr0;
            end
            if (state == RESP) begin
                prio <= ~gnt;
            end
            if (capture) begin
                if (gnt) begin
                    rdata1 <= dp_data;
                    hit1   <= cap_hit;
                end else begin
                    rdata0 <= dp_data;
                    hit0   <= cap_hit;
                end
            end
        end
    end

`ifdef CACHE_PORT_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (capture) begin
            if (cap_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (!cap_hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Testbench for cache_port_arbiter (default parameters: HIT_LAT=1,
// MISS_LAT=4). Stimulus pushes expected responses into a queue; a monitor
// pops and compares whenever an ack appears. Statistics checks are built
// when CACHE_PORT_ARBITER_STATS_EN is defined.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, hit0, hit1, busy;
    logic [31:0] rdata0, rdata1;
    logic [14:0] dp_addr;
    logic        dp_hit = 1'b0;
    logic [31:0] dp_data;
    logic        stats_clr = 1'b0;
    logic [15:0] hit_cnt, miss_cnt;

    // Datapath model: either address-derived data, or an early value that
    // switches to a late value from cycle sw_cyc onwards.
    logic        addr_mode = 1'b0;
    logic [31:0] dp_early = '0, dp_late = '0;
    int          sw_cyc = 0;
    int          cyc = 0;

    assign dp_data = addr_mode ? {17'h15A5A, dp_addr}
                               : ((cyc >= sw_cyc) ? dp_late : dp_early);

    cache_port_arbiter #(
        .ADDR_W(15), .DATA_W(32), .HIT_LAT(1), .MISS_LAT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .hit0(hit0), .hit1(hit1),
        .dp_addr(dp_addr), .dp_hit(dp_hit), .dp_data(dp_data),
`ifdef CACHE_PORT_ARBITER_STATS_EN
        .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .busy(busy)
    );

`ifndef CACHE_PORT_ARBITER_STATS_EN
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        hit;
        int          at;
    } exp_t;

    exp_t        q[$];
    logic [31:0] md[2];
    logic        mh[2];

    // Monitor: compares every ack against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            md[0] = '0; md[1] = '0; mh[0] = 1'b0; mh[1] = 1'b0;
        end else if (ack0 || ack1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with nothing expected (cycle %0d)",
                         ack0, ack1, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                md[e.port] = e.data;
                mh[e.port] = e.hit;
                chk("ack_both",  {63'd0, ack0 & ack1}, 64'd0);
                chk("ack_port",  {63'd0, ack1}, 64'(e.port));
                chk("ack_cycle", 64'(cyc), 64'(e.at));
                chk("rdata0",    64'(rdata0), 64'(md[0]));
                chk("rdata1",    64'(rdata1), 64'(md[1]));
                chk("hit0",      {63'd0, hit0}, {63'd0, mh[0]});
                chk("hit1",      {63'd0, hit1}, {63'd0, mh[1]});
            end
        end
    end

    // One request with a single requester; checks dp_addr over the whole
    // access window and optionally pulses stats_clr on the capture edge.
    task automatic do_req(input int port, input logic [14:0] a, input logic h,
                          input logic [31:0] early, input logic [31:0] late,
                          input bit clr);
        int   g, lat;
        bit   got;
        exp_t e;
        @(negedge clk);
        g         = cyc + 1;
        lat       = h ? 1 : 5;
        addr_mode = 1'b0;
        dp_hit    = h;
        dp_early  = early;
        dp_late   = late;
        sw_cyc    = g + 3;
        e.port = port; e.data = late; e.hit = h; e.at = g + lat;
        q.push_back(e);
        if (port == 0) begin addr0 = a; req0 = 1'b1; end
        else           begin addr1 = a; req1 = 1'b1; end
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cyc >= g && cyc < g + lat) chk("dp_addr", 64'(dp_addr), 64'(a));
            stats_clr = (clr && cyc == g + lat - 1);
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                got  = 1;
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        stats_clr = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: port %0d got no ack, required within 40 cycles", port);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g, n;
        exp_t e;
        // Reset state
        #1;
        chk("rst_ack0", {63'd0, ack0}, 64'd0);
        chk("rst_ack1", {63'd0, ack1}, 64'd0);
        chk("rst_rdata0", 64'(rdata0), 64'd0);
        chk("rst_rdata1", 64'(rdata1), 64'd0);
        chk("rst_dp_addr", 64'(dp_addr), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Port 0 hit
        do_req(0, 15'h0010, 1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 0);
        // Port 1 miss, data refilled part way through the window
        do_req(1, 15'h1234, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 0);

        // Both ports requesting continuously: grants 0,1,0
        @(negedge clk);
        g         = cyc + 1;
        addr_mode = 1'b1;
        dp_hit    = 1'b1;
        addr0     = 15'h0100;
        addr1     = 15'h0200;
        e.hit = 1'b1;
        e.port = 0; e.data = {17'h15A5A, 15'h0100}; e.at = g + 1; q.push_back(e);
        e.port = 1; e.data = {17'h15A5A, 15'h0200}; e.at = g + 4; q.push_back(e);
        e.port = 0; e.data = {17'h15A5A, 15'h0100}; e.at = g + 7; q.push_back(e);
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
            if (n == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        chk("alt_ack_count", 64'(n), 64'd3);

        // Reset in the middle of a port-1 miss
        @(negedge clk);
        g         = cyc + 1;
        addr_mode = 1'b0;
        dp_hit    = 1'b0;
        dp_early  = 32'h5555_5555;
        dp_late   = 32'h5555_5555;
        addr1     = 15'h0777;
        req1      = 1'b1;
        while (cyc < g + 1) @(negedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req1 = 1'b0;
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_dp_addr", 64'(dp_addr), 64'd0);
        chk("mid_ack1", {63'd0, ack1}, 64'd0);
        chk("mid_rdata1", 64'(rdata1), 64'd0);
        chk("mid_hit0", {63'd0, hit0}, 64'd0);
        repeat (8) @(negedge clk);
        rst = 1'b1;

        // Both request after reset: port 0 must win
        @(negedge clk);
        g        = cyc + 1;
        dp_hit   = 1'b1;
        dp_early = 32'h0BAD_F00D;
        dp_late  = 32'h0BAD_F00D;
        addr0    = 15'h0005;
        addr1    = 15'h0006;
        e.port = 0; e.data = 32'h0BAD_F00D; e.hit = 1'b1; e.at = g + 1; q.push_back(e);
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 1; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin n++; req0 = 1'b0; req1 = 1'b0; end
        end
        chk("post_rst_acks", 64'(n), 64'd1);

        // Traffic mix: 3 hits (including the one above) and 2 misses
        do_req(1, 15'h0042, 1'b1, 32'h0000_0042, 32'h0000_0042, 0);
        do_req(0, 15'h0043, 1'b1, 32'h0000_0043, 32'h0000_0043, 0);
        do_req(0, 15'h0050, 1'b0, 32'h0000_0000, 32'hCAFE_0050, 0);
        do_req(1, 15'h0051, 1'b0, 32'h0000_0000, 32'hCAFE_0051, 0);
`ifdef CACHE_PORT_ARBITER_STATS_EN
        chk("hit_cnt", 64'(hit_cnt), 64'd3);
        chk("miss_cnt", 64'(miss_cnt), 64'd2);
`endif
        // Clear collides with a hit capture edge: clear wins
        do_req(0, 15'h0060, 1'b1, 32'h0000_0060, 32'h0000_0060, 1);
`ifdef CACHE_PORT_ARBITER_STATS_EN
        chk("hit_cnt_clr", 64'(hit_cnt), 64'd0);
        chk("miss_cnt_clr", 64'(miss_cnt), 64'd0);
`endif

        repeat (4) @(negedge clk);
        chk("pending_expected", 64'(q.size()), 64'd0);
        chk("final_busy", {63'd0, busy}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
